// File: rtl/bster_pkg.sv
// Shared constants for the AXI memory driver: FSM state encodings, AXI response
// codes and a response classification helper.
package bster_pkg;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] ST_WR_RESP      = 3'd2;
  localparam logic [2:0] ST_RD_ADDR      = 3'd3;
  localparam logic [2:0] ST_RD_DATA      = 3'd4;
  localparam logic [2:0] ST_RD_CPL       = 3'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything other than OKAY is treated as a failed beat.
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_mem_driver.sv
// Single-outstanding AXI4-Lite master turning engine node reads/writes into AXI beats.
// Optional response watchdog enabled by defining MEM_DRIVER_TIMEOUT_EN.
module axi_mem_driver
  import bster_pkg::*;
#(
  parameter int RAM_DATA_WIDTH = 32,
  parameter int RAM_ADDR_WIDTH = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic                        mem_rd,
  input  logic                        mem_wr,
  input  logic [RAM_ADDR_WIDTH-1:0]   mem_addr,
  input  logic [RAM_DATA_WIDTH-1:0]   mem_wr_data,
  output logic                        mem_rd_valid,
  input  logic                        mem_rd_ready,
  output logic [RAM_DATA_WIDTH-1:0]   mem_rd_data,
  output logic                        mem_error,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [RAM_ADDR_WIDTH-1:0]   awaddr,
  output logic                        wvalid,
  input  logic                        wready,
  output logic [RAM_DATA_WIDTH-1:0]   wdata,
  output logic [RAM_DATA_WIDTH/8-1:0] wstrb,
  input  logic                        bvalid,
  output logic                        bready,
  input  logic [1:0]                  bresp,
  output logic                        arvalid,
  input  logic                        arready,
  output logic [RAM_ADDR_WIDTH-1:0]   araddr,
  input  logic                        rvalid,
  output logic                        rready,
  input  logic [RAM_DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]                  rresp
);

  logic [2:0]                state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [RAM_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                      mem_ready_q, mem_ready_d;
  logic                      mem_rd_valid_q, mem_rd_valid_d;
  logic                      mem_error_q, mem_error_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      bready_q, bready_d;
  logic                      arvalid_q, arvalid_d;
  logic                      rready_q, rready_d;
  logic                      err_set_s;

`ifdef MEM_DRIVER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

  // Next-state and output-register computation for the transaction FSM.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    rd_data_d      = rd_data_q;
    mem_ready_d    = mem_ready_q;
    mem_rd_valid_d = mem_rd_valid_q;
    awvalid_d      = awvalid_q;
    wvalid_d       = wvalid_q;
    bready_d       = bready_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    err_set_s      = 1'b0;
`ifdef MEM_DRIVER_TIMEOUT_EN
    tmo_d          = tmo_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (mem_valid && (mem_wr || mem_rd)) begin
          mem_ready_d = 1'b0;
          addr_d      = mem_addr;
          if (mem_wr) begin
            // A request flagged as both read and write is served as a write only.
            wdata_d   = mem_wr_data;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            err_set_s = mem_rd;
            state_d   = ST_WR_ADDR_DATA;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR_ADDR_DATA: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
`ifdef MEM_DRIVER_TIMEOUT_EN
          tmo_d    = '0;
`endif
        end else begin
          state_d = ST_WR_ADDR_DATA;
        end
      end
      ST_WR_RESP: begin
        if (bvalid) begin
          bready_d    = 1'b0;
          mem_ready_d = 1'b1;
          err_set_s   = resp_is_err(bresp);
          state_d     = ST_IDLE;
        end else begin
`ifdef MEM_DRIVER_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            bready_d    = 1'b0;
            mem_ready_d = 1'b1;
            err_set_s   = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
`else
          state_d = ST_WR_RESP;
`endif
        end
      end
      ST_RD_ADDR: begin
        if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
`ifdef MEM_DRIVER_TIMEOUT_EN
          tmo_d     = '0;
`endif
        end else begin
          state_d = ST_RD_ADDR;
        end
      end
      ST_RD_DATA: begin
        if (rvalid) begin
          rready_d       = 1'b0;
          rd_data_d      = rdata;
          mem_rd_valid_d = 1'b1;
          err_set_s      = resp_is_err(rresp);
          state_d        = ST_RD_CPL;
        end else begin
`ifdef MEM_DRIVER_TIMEOUT_EN
          // A dead slave still completes the read, with zero data and the error flag.
          if (tmo_q == TMO_LAST) begin
            rready_d       = 1'b0;
            rd_data_d      = '0;
            mem_rd_valid_d = 1'b1;
            err_set_s      = 1'b1;
            state_d        = ST_RD_CPL;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
`else
          state_d = ST_RD_DATA;
`endif
        end
      end
      ST_RD_CPL: begin
        if (mem_rd_ready) begin
          mem_rd_valid_d = 1'b0;
          mem_ready_d    = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          state_d = ST_RD_CPL;
        end
      end
      default: begin
        mem_ready_d    = 1'b1;
        mem_rd_valid_d = 1'b0;
        awvalid_d      = 1'b0;
        wvalid_d       = 1'b0;
        bready_d       = 1'b0;
        arvalid_d      = 1'b0;
        rready_d       = 1'b0;
        err_set_s      = 1'b1;
        state_d        = ST_IDLE;
      end
    endcase
  end

  assign mem_error_d = mem_error_q | err_set_s;

  // State and output registers; mem_ready comes out of reset high.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      rd_data_q      <= '0;
      mem_ready_q    <= 1'b1;
      mem_rd_valid_q <= 1'b0;
      mem_error_q    <= 1'b0;
      awvalid_q      <= 1'b0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
`ifdef MEM_DRIVER_TIMEOUT_EN
      tmo_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      rd_data_q      <= rd_data_d;
      mem_ready_q    <= mem_ready_d;
      mem_rd_valid_q <= mem_rd_valid_d;
      mem_error_q    <= mem_error_d;
      awvalid_q      <= awvalid_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
`ifdef MEM_DRIVER_TIMEOUT_EN
      tmo_q          <= tmo_d;
`endif
    end
  end

  assign mem_ready    = mem_ready_q;
  assign mem_rd_valid = mem_rd_valid_q;
  assign mem_rd_data  = rd_data_q;
  assign mem_error    = mem_error_q;
  assign awvalid      = awvalid_q;
  assign awaddr       = addr_q;
  assign wvalid       = wvalid_q;
  assign wdata        = wdata_q;
  assign wstrb        = {(RAM_DATA_WIDTH/8){1'b1}};
  assign bready       = bready_q;
  assign arvalid      = arvalid_q;
  assign araddr       = addr_q;
  assign rready       = rready_q;

endmodule
